hex_keypad_scanner: RTL

//  Input-side companion to the 4-digit seven-segment driver. Scans a 4x4 hex matrix keypad
//  (active-low columns driven, active-low rows sensed), debounces, decodes one hex key per press
//  and shifts it into a 16-bit entry register. The 16-bit register feeds the display din directly.

---
 rtl/hex_keypad_scanner.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: rotates an active-low column strobe, debounces the sensed rows,
// decodes one key per press and shifts it into a 16-bit entry register.
module hex_keypad_scanner #(
   parameter int SCAN_DIV     = 32768,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  rows,
   input  logic        clear,
   output logic [3:0]  cols,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_down,
   output logic [15:0] entry
);

   localparam int TW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_CNT);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   logic [3:0]    rows_p0;
   logic [3:0]    rs;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   state_t        state;
   logic [1:0]    cand_row;
   logic [1:0]    cand_col;
   logic [CW-1:0] cnt;
   logic [CW-1:0] rel_cnt;
   logic          row_hit;
   logic [1:0]    row_idx;
   logic [1:0]    col_idx;
   logic [1:0]    acc_row;
   logic [1:0]    acc_col;
   logic [3:0]    new_code;
   logic          acc_scan;
   logic          acc_deb;
   logic          accept;

   // {hit, index} of the lowest-index low row; hit=0 when no row is pulled low
   function automatic logic [2:0] row_decode(input logic [3:0] r);
      logic [2:0] res;
      res = 3'b000;
      if (!r[0])      res = 3'b100;
      else if (!r[1]) res = 3'b101;
      else if (!r[2]) res = 3'b110;
      else if (!r[3]) res = 3'b111;
      return res;
   endfunction

   function automatic logic [1:0] col_decode(input logic [3:0] c);
      logic [1:0] res;
      res = 2'd3;
      if (!c[0])      res = 2'd0;
      else if (!c[1]) res = 2'd1;
      else if (!c[2]) res = 2'd2;
      return res;
   endfunction

   function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'b00_00: k = 4'h1;
         4'b00_01: k = 4'h2;
         4'b00_10: k = 4'h3;
         4'b00_11: k = 4'hA;
         4'b01_00: k = 4'h4;
         4'b01_01: k = 4'h5;
         4'b01_10: k = 4'h6;
         4'b01_11: k = 4'hB;
         4'b10_00: k = 4'h7;
         4'b10_01: k = 4'h8;
         4'b10_10: k = 4'h9;
         4'b10_11: k = 4'hC;
         4'b11_00: k = 4'hE;
         4'b11_01: k = 4'h0;
         4'b11_10: k = 4'hF;
         default:  k = 4'hD;
      endcase
      return k;
   endfunction

   function automatic logic [3:0] rotl(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

   // Stage p0/p1: two-flop row synchroniser
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows_p0 <= 4'hF;
         rs      <= 4'hF;
      end else begin
         rows_p0 <= rows;
         rs      <= rows_p0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + TICK_ONE;
   end

   assign tick                = (tick_cnt == TICK_LAST);
   assign {row_hit, row_idx}  = row_decode(rs);
   assign col_idx             = col_decode(cols);

   // A single-sample debounce accepts straight from SCAN using the live position
   assign acc_row  = (state == SCAN) ? row_idx : cand_row;
   assign acc_col  = (state == SCAN) ? col_idx : cand_col;
   assign new_code = keymap(acc_row, acc_col);
   assign acc_scan = tick && (state == SCAN) && row_hit && (DEBOUNCE_CNT == 1);
   assign acc_deb  = tick && (state == DEBOUNCE) && row_hit && (row_idx == cand_row)
                     && ((cnt + CNT_ONE) == CNT_DONE);
   assign accept   = acc_scan || acc_deb;

   // Stage p2: scan FSM and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SCAN;
         cols      <= 4'b1110;
         cand_row  <= 2'd0;
         cand_col  <= 2'd0;
         cnt       <= '0;
         rel_cnt   <= '0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         key_down  <= 1'b0;
         entry     <= 16'h0000;
      end else begin
         key_valid <= 1'b0;
         if (accept) begin
            key_valid <= 1'b1;
            key_code  <= new_code;
            entry     <= clear ? 16'h0000 : {entry[11:0], new_code};
         end else if (clear) begin
            entry <= 16'h0000;
         end

         if (tick) begin
            case (state)
               SCAN: begin
                  if (row_hit) begin
                     cand_row <= row_idx;
                     cand_col <= col_idx;
                     cnt      <= CNT_ONE;
                     if (DEBOUNCE_CNT == 1) begin
                        state    <= HELD;
                        key_down <= 1'b1;
                        rel_cnt  <= '0;
                     end else begin
                        state <= DEBOUNCE;
                     end
                  end else begin
                     cols <= rotl(cols);
                  end
               end
               DEBOUNCE: begin
                  if (row_hit && (row_idx == cand_row)) begin
                     if ((cnt + CNT_ONE) == CNT_DONE) begin
                        state    <= HELD;
                        key_down <= 1'b1;
                        rel_cnt  <= '0;
                     end else begin
                        cnt <= cnt + CNT_ONE;
                     end
                  end else begin
                     state <= SCAN;
                     cols  <= rotl(cols);
                  end
               end
               HELD: begin
                  if (row_hit) begin
                     rel_cnt <= '0;
                  end else if ((rel_cnt + CNT_ONE) == CNT_DONE) begin
                     state    <= SCAN;
                     key_down <= 1'b0;
                     rel_cnt  <= '0;
                  end else begin
                     rel_cnt <= rel_cnt + CNT_ONE;
                  end
               end
               default: begin
                  state    <= SCAN;
                  key_down <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
